button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Front-end conditioning stage directly upstream of the LED show block.
- Takes the raw, asynchronous, bouncing push-button pin and synchronises it into the clock domain.
- Filters bounce with a counter-qualified state machine and drives a clean level onto the LED block's pushButton input.
- Also emits one-cycle press/release strobes for other consumers.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles of a new level required to accept it; must be >= 1.
- HOLD_CYCLES, 16, cycles in PRESSED before the long-press strobe fires (LONG_PRESS_EN only); must be >= 1.
- CNT_WIDTH, 16, counter width; 2**CNT_WIDTH must exceed max(DEBOUNCE_CYCLES, HOLD_CYCLES).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rstN  input  1  asynchronous active-low reset.
- buttonRaw  input  1  raw button pin, asynchronous to clk, 1 = pressed.
- pushButton  output  1  debounced level; feeds the LED show block's pushButton input.
- pressPulse  output  1  one-cycle strobe on accepted 0->1 transition.
- releasePulse  output  1  one-cycle strobe on accepted 1->0 transition.
- longPress  output  1  one-cycle strobe after a sustained press; tied 0 without LONG_PRESS_EN.

Behaviour:
- Reset (rstN=0, asynchronous):
  - sync flops, state, debounce counter and hold counter all go to 0/RELEASED immediately.
  - pushButton, pressPulse, releasePulse and longPress go to 0 immediately.
  - Effect is the same mid-operation, including in CONFIRM_* or PRESSED. No strobe is issued on reset entry or exit.
- Synchroniser: two flops, buttonRaw -> s1 -> syncBtn. The FSM uses only syncBtn.
- FSM states: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE. All outputs are registered.
- RELEASED:
  - syncBtn=1 -> CONFIRM_PRESS, cnt<=0.
  - Otherwise stay.
- CONFIRM_PRESS:
  - syncBtn=0 -> RELEASED, cnt<=0 (bounce rejected, no output change).
  - syncBtn=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, pushButton<=1, pressPulse<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- PRESSED: mirror of RELEASED; syncBtn=0 -> CONFIRM_RELEASE, cnt<=0.
- CONFIRM_RELEASE:
  - syncBtn=1 -> PRESSED, cnt<=0 (no output change).
  - syncBtn=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED, pushButton<=0, releasePulse<=1.
  - Otherwise cnt<=cnt+1.
- Latency: if buttonRaw is first sampled high at edge k and stays stable, pushButton and pressPulse go high after edge k+2+DEBOUNCE_CYCLES. Release is symmetric.
- Strobes are high for exactly one cycle and cleared on the next edge.
- pressPulse and releasePulse are never high together.
- Any interruption shorter than DEBOUNCE_CYCLES synchronised cycles leaves pushButton unchanged and produces no strobe.
- The counter never wraps: it resets on every state change and stops at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BUTTON_LONG_PRESS_EN.
- Defined:
  - A hold counter clears on entry to PRESSED and increments each cycle while in PRESSED.
  - It does not clear during CONFIRM_RELEASE if release is rejected; it keeps counting.
  - When holdCnt reaches HOLD_CYCLES-1 in PRESSED, longPress pulses 1 for one cycle, then holdCnt saturates. No repeat until the next accepted press.
  - The hold counter clears on an accepted release and on reset.
- Not defined: longPress is constant 0, the hold counter is absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: rstN low for 3 cycles, buttonRaw=0 -> all outputs 0 throughout, state RELEASED.
- Clean press, DEBOUNCE_CYCLES=4: buttonRaw 0->1 sampled at edge 10, held -> pushButton=1 and pressPulse=1 after edge 16 only, pressPulse=0 after edge 17.
- Bounce rejection: buttonRaw high 3 cycles, low 1, high 2, low -> pushButton stays 0, no strobes.
- Clean release: from PRESSED, buttonRaw 1->0 held 10 cycles -> releasePulse one cycle, pushButton=0 six edges after the first low sample.
- Async reset mid-confirm: assert rstN=0 between edges during CONFIRM_PRESS with cnt=2 -> outputs 0 immediately. After release of reset with buttonRaw still 1, a full 2+4-edge qualification is needed before pushButton=1.
- BUTTON_LONG_PRESS_EN, HOLD_CYCLES=16: hold button 40 cycles after pushButton rises -> exactly one longPress pulse, 16 edges after pressPulse. Without the macro, longPress=0 throughout.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw, bouncing push-button pin and filters it
// with a counter-qualified four-state FSM. Drives a clean level (pushButton)
// plus one-cycle press/release strobes. All outputs are registered.
//
// Optional feature, enabled by defining BUTTON_LONG_PRESS_EN: a hold counter
// fires a single longPress strobe HOLD_CYCLES cycles after an accepted press.
// Without the macro, longPress is tied low and the hold counter is absent.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic rstN,
    input  logic buttonRaw,
    output logic pushButton,
    output logic pressPulse,
    output logic releasePulse,
    output logic longPress
);

    // Reject nonsensical configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("button_debouncer: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync_s1;
    logic                 sync_btn;
    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 push_nxt;
    logic                 press_nxt;
    logic                 release_nxt;

    // Two-flop synchroniser; only sync_btn is allowed to reach the FSM.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_s1  <= 1'b0;
            sync_btn <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample on the same
            // edge; blocking here would collapse the chain into a single flop.
            sync_s1  <= buttonRaw;
            sync_btn <= sync_s1;
        end
    end

    // Next-state, debounce counter and next output values.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        push_nxt    = pushButton;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            RELEASED: begin
                if (sync_btn) begin
                    state_nxt = CONFIRM_PRESS;
                    cnt_nxt   = '0;
                end
            end
            CONFIRM_PRESS: begin
                if (!sync_btn) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    push_nxt  = 1'b1;
                    press_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync_btn) begin
                    state_nxt = CONFIRM_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            CONFIRM_RELEASE: begin
                if (sync_btn) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = RELEASED;
                    push_nxt    = 1'b0;
                    release_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
                push_nxt  = 1'b0;
            end
        endcase
    end

    // State register, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= RELEASED;
            cnt          <= '0;
            pushButton   <= 1'b0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pushButton   <= push_nxt;
            pressPulse   <= press_nxt;
            releasePulse <= release_nxt;
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_DONE = CNT_WIDTH'(HOLD_CYCLES);

    logic [CNT_WIDTH-1:0] hold_cnt;
    logic [CNT_WIDTH-1:0] hold_nxt;
    logic                 long_nxt;

    // Hold counter: clears on accepted press/release, keeps counting through a
    // rejected release, fires once from PRESSED and then parks at HOLD_DONE.
    always_comb begin
        hold_nxt = hold_cnt;
        long_nxt = 1'b0;
        if (state == CONFIRM_PRESS && state_nxt == PRESSED) begin
            hold_nxt = '0;
        end else if (state == CONFIRM_RELEASE && state_nxt == RELEASED) begin
            hold_nxt = '0;
        end else if (state == PRESSED) begin
            if (hold_cnt == HOLD_LAST) begin
                long_nxt = 1'b1;
                hold_nxt = HOLD_DONE;
            end else if (hold_cnt < HOLD_LAST) begin
                hold_nxt = hold_cnt + 1'b1;
            end
        end else if (state == CONFIRM_RELEASE && hold_cnt < HOLD_LAST) begin
            // Wait at HOLD_LAST so the strobe only ever fires from PRESSED.
            hold_nxt = hold_cnt + 1'b1;
        end
    end

    // Hold counter and long-press strobe registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hold_cnt  <= '0;
            longPress <= 1'b0;
        end else begin
            hold_cnt  <= hold_nxt;
            longPress <= long_nxt;
        end
    end
`else
    // Long-press detection not built in.
    assign longPress = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed stimulus for button_debouncer. Stimulus pushes
// the expected strobe events (kind + edge number) into a queue; a monitor pops
// and compares whenever a strobe is seen. Level checks are made inline.
module tb_button_debouncer;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    // Input changed just after edge n is first sampled at n+1; the accepted
    // transition is visible after edge n+1+2+DEB.
    localparam int LAT  = 3 + DEB;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic buttonRaw = 1'b0;
    logic pushButton;
    logic pressPulse;
    logic releasePulse;
    logic longPress;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int unsigned at;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned edge_no = 0;
    int          long_seen = 0;
    int          long_exp = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .CNT_WIDTH      (16)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .buttonRaw   (buttonRaw),
        .pushButton  (pushButton),
        .pressPulse  (pressPulse),
        .releasePulse(releasePulse),
        .longPress   (longPress)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int unsigned at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
        if (k == EV_LONG) long_exp++;
    endtask

    task automatic observe(input ev_kind_t k, input logic lvl);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: strobe at edge %0d, none expected", k.name(), edge_no);
        end else begin
            e = exp_q.pop_front();
            check({"kind_", k.name()}, k, e.kind);
            check({"edge_", k.name()}, edge_no, e.at);
            check({"level_", k.name()}, pushButton, lvl);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (pressPulse || releasePulse)
            check("strobe_exclusive", pressPulse & releasePulse, 0);
        if (pressPulse)   observe(EV_PRESS, 1'b1);
        if (releasePulse) observe(EV_RELEASE, 1'b0);
        if (longPress) begin
            long_seen++;
            observe(EV_LONG, 1'b1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_press(input bit with_long);
        expect_ev(EV_PRESS, edge_no + LAT);
`ifdef BUTTON_LONG_PRESS_EN
        if (with_long) expect_ev(EV_LONG, edge_no + LAT + HOLD);
`else
        if (with_long) begin end
`endif
        buttonRaw = 1'b1;
    endtask

    task automatic start_release();
        expect_ev(EV_RELEASE, edge_no + LAT);
        buttonRaw = 1'b0;
    endtask

    initial begin
        // Reset then idle.
        rstN = 1'b0;
        buttonRaw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {pushButton, pressPulse, releasePulse, longPress}, 0);
        end
        rstN = 1'b1;
        cyc(5);
        check("idle_level", pushButton, 0);

        // Clean press held long enough for a long press, then clean release.
        start_press(1'b1);
        cyc(50);
        check("held_level", pushButton, 1);
        start_release();
        cyc(12);
        check("released_level", pushButton, 0);

        // Bounce: high 3, low 1, high 2, low -> nothing accepted.
        buttonRaw = 1'b1; cyc(3);
        buttonRaw = 1'b0; cyc(1);
        buttonRaw = 1'b1; cyc(2);
        buttonRaw = 1'b0; cyc(12);
        check("bounce_level", pushButton, 0);

        // Press with a 3-cycle release glitch; hold count survives the glitch.
        start_press(1'b1);
        cyc(10);
        buttonRaw = 1'b0; cyc(3);
        buttonRaw = 1'b1; cyc(4);
        check("glitch_level", pushButton, 1);
        cyc(16);
        start_release();
        cyc(12);

        // Async reset in CONFIRM_PRESS with cnt=2, button still held.
        buttonRaw = 1'b1;
        cyc(5);
        #2 rstN = 1'b0;
        #1 check("reset_confirm_outputs", {pushButton, pressPulse, releasePulse, longPress}, 0);
        cyc(2);
        rstN = 1'b1;
        start_press(1'b0);
        cyc(LAT + 3);
        check("requalified_level", pushButton, 1);

        // Async reset while PRESSED: level drops at once, no strobe on exit.
        #2 rstN = 1'b0;
        #1 check("reset_pressed_outputs", {pushButton, pressPulse, releasePulse, longPress}, 0);
        buttonRaw = 1'b0;
        cyc(2);
        rstN = 1'b1;
        cyc(12);
        check("post_reset_level", pushButton, 0);

        // Drain any outstanding expectations within a bounded window.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("long_count", long_seen, long_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
